// File: rtl/countdown_timer.sv
// Prescaled countdown timer: loads a count, decrements once per prescaled tick, and
// flags expiry with a one-cycle strobe and a sticky interrupt. Define TIMER_AUTORELOAD_EN for periodic reload.
module countdown_timer #(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      start,
  input  logic                      stop,
  input  logic [WIDTH-1:0]          load_value,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      irq_ack,
  output logic [WIDTH-1:0]          count_value,
  output logic                      busy,
  output logic                      irq,
  output logic                      expired_pulse
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t                    state_reg, state_next;
  logic [WIDTH-1:0]          count_reg, count_next;
  logic [PRESCALE_WIDTH-1:0] prescaler_reg, prescaler_next;
  logic [PRESCALE_WIDTH-1:0] prescale_reg, prescale_next;
  logic                      busy_reg, busy_next;
  logic                      irq_reg, irq_next;
  logic                      pulse_reg, pulse_next;
  logic                      tick;
  logic                      expiry;
`ifdef TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0]          reload_reg, reload_next;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      prescaler_reg <= '0;
      prescale_reg  <= '0;
      busy_reg      <= 1'b0;
      irq_reg       <= 1'b0;
      pulse_reg     <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      reload_reg    <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      prescaler_reg <= prescaler_next;
      prescale_reg  <= prescale_next;
      busy_reg      <= busy_next;
      irq_reg       <= irq_next;
      pulse_reg     <= pulse_next;
`ifdef TIMER_AUTORELOAD_EN
      reload_reg    <= reload_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    prescaler_next = prescaler_reg;
    prescale_next  = prescale_reg;
    pulse_next     = 1'b0;
    tick           = 1'b0;
    expiry         = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
    reload_next    = reload_reg;
`endif

    // stop outranks start, and both outrank the prescaled tick
    if (stop) begin
      state_next = IDLE;
    end else if (start) begin
      state_next     = RUNNING;
      count_next     = load_value;
      prescale_next  = prescale;
      prescaler_next = '0;
`ifdef TIMER_AUTORELOAD_EN
      reload_next    = load_value;
`endif
    end else if (state_reg == RUNNING && enable) begin
      if (prescaler_reg == prescale_reg) begin
        tick           = 1'b1;
        prescaler_next = '0;
      end else begin
        prescaler_next = prescaler_reg + 1'b1;
      end
      if (tick) begin
        // counts of 1 and 0 both expire, so the count never wraps to all-ones
        if (count_reg > WIDTH'(1)) begin
          count_next = count_reg - 1'b1;
        end else begin
          expiry = 1'b1;
        end
      end
    end

    if (expiry) begin
      pulse_next = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
      count_next = reload_reg;
`else
      count_next = '0;
      state_next = EXPIRED;
`endif
    end

    if (expiry) begin
      irq_next = 1'b1;
    end else if (irq_ack) begin
      irq_next = 1'b0;
    end else begin
      irq_next = irq_reg;
    end

    busy_next = (state_next == RUNNING);
  end

  assign count_value   = count_reg;
  assign busy          = busy_reg;
  assign irq           = irq_reg;
  assign expired_pulse = pulse_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer; expected values are hand-derived from the timer's
// cycle timing, with TIMER_AUTORELOAD_EN selecting the reload-mode expectations.
module tb_countdown_timer;

  localparam int WIDTH          = 8;
  localparam int PRESCALE_WIDTH = 4;
`ifdef TIMER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic                      clock;
  logic                      reset;
  logic                      enable;
  logic                      start;
  logic                      stop;
  logic [WIDTH-1:0]          load_value;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      irq_ack;
  logic [WIDTH-1:0]          count_value;
  logic                      busy;
  logic                      irq;
  logic                      expired_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  countdown_timer #(
    .WIDTH          (WIDTH),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .start         (start),
    .stop          (stop),
    .load_value    (load_value),
    .prescale      (prescale),
    .irq_ack       (irq_ack),
    .count_value   (count_value),
    .busy          (busy),
    .irq           (irq),
    .expired_pulse (expired_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [WIDTH-1:0] n, input logic [PRESCALE_WIDTH-1:0] p);
    $display("start: load_value=%0d prescale=%0d", n, p);
    load_value = n;
    prescale   = p;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; start = 1'b0; stop = 1'b0;
    load_value = '0; prescale = '0; irq_ack = 1'b0;
    step(); step();
    check("rst_count", count_value, 0);
    check("rst_busy", busy, 0);
    check("rst_irq", irq, 0);
    check("rst_pulse", expired_pulse, 0);
    reset = 1'b0;
    step();

    // one-shot: 3,2,1,0 with the strobe on the first 0
    do_start(3, 0);
    check("os_load", count_value, 3);
    check("os_busy", busy, 1);
    check("os_pulse0", expired_pulse, 0);
    step(); check("os_c2", count_value, 2);
    step(); check("os_c1", count_value, 1);
    check("os_pulse1", expired_pulse, 0);
    step();
    check("os_exp_count", count_value, AR ? 3 : 0);
    check("os_exp_pulse", expired_pulse, 1);
    check("os_exp_irq", irq, 1);
    check("os_exp_busy", busy, AR ? 1 : 0);
    do_stop();
    check("os_stop_count", count_value, AR ? 3 : 0);
    check("os_stop_busy", busy, 0);
    check("os_stop_pulse", expired_pulse, 0);
    check("os_stop_irq", irq, 1);
    $display("irq_ack");
    irq_ack = 1'b1;
    step(); check("ack_clear", irq, 0);
    step(); check("ack_idle", irq, 0);
    irq_ack = 1'b0;

    // prescale 3, two frozen cycles: expiry lands 10 cycles after start, ack collides with it
    do_start(2, 3);
    for (int c = 1; c <= 10; c++) begin
      enable  = (c == 3 || c == 4) ? 1'b0 : 1'b1;
      irq_ack = (c == 2 || c == 10) ? 1'b1 : 1'b0;
      step();
      check($sformatf("ps_pulse_c%0d", c), expired_pulse, (c == 10) ? 1 : 0);
      check($sformatf("ps_count_c%0d", c), count_value,
            (c < 6) ? 2 : ((c < 10) ? 1 : (AR ? 2 : 0)));
    end
    check("ps_irq_setwins", irq, 1);
    enable = 1'b1; irq_ack = 1'b0;
    do_stop();
    check("ps_irq_held", irq, 1);
    irq_ack = 1'b1;
    step(); check("ps_irq_ack", irq, 0);
    irq_ack = 1'b0;

    // simultaneous start and stop: stop wins, count held
    do_start(7, 0);
    check("pri_load", count_value, 7);
    step(); check("pri_c6", count_value, 6);
    $display("start+stop together");
    start = 1'b1; stop = 1'b1; load_value = 9;
    step();
    start = 1'b0; stop = 1'b0;
    check("pri_busy", busy, 0);
    check("pri_count", count_value, 6);
    step();
    check("pri_idle_count", count_value, 6);
    check("pri_idle_busy", busy, 0);

    // load 0, prescale 1: expiry on the first tick, two cycles after start
    do_start(0, 1);
    check("z_load", count_value, 0);
    check("z_busy", busy, 1);
    step(); check("z_pulse_c1", expired_pulse, 0);
    step();
    check("z_pulse_c2", expired_pulse, 1);
    check("z_irq", irq, 1);
    check("z_busy_exp", busy, AR ? 1 : 0);
    check("z_count", count_value, 0);
    do_stop();

    // full-scale count expires after 255 cycles without wrapping
    do_start(255, 0);
    check("max_load", count_value, 255);
    repeat (253) step();
    step();
    check("max_c254", count_value, 1);
    check("max_pulse_c254", expired_pulse, 0);
    step();
    check("max_pulse", expired_pulse, 1);
    check("max_count", count_value, AR ? 255 : 0);
    do_stop();

    // restart during a run reloads immediately
    do_start(5, 0);
    step(); step();
    check("rs_c3", count_value, 3);
    do_start(4, 0);
    check("rs_reload", count_value, 4);
    check("rs_busy", busy, 1);

    // asynchronous reset between clock edges
    do_start(5, 2);
    check("ar_pre_count", count_value, 5);
    check("ar_pre_irq", irq, 1);
    $display("async reset mid-run");
    #2 reset = 1'b1;
    #1;
    check("ar_count", count_value, 0);
    check("ar_busy", busy, 0);
    check("ar_irq", irq, 0);
    check("ar_pulse", expired_pulse, 0);
    #1 reset = 1'b0;
    step();
    check("ar_post_count", count_value, 0);
    check("ar_post_busy", busy, 0);

`ifdef TIMER_AUTORELOAD_EN
    // periodic reload: count alternates 2,1 with a strobe every second cycle
    do_start(2, 0);
    for (int c = 1; c <= 6; c++) begin
      step();
      check($sformatf("rl_count_c%0d", c), count_value, (c % 2 == 1) ? 1 : 2);
      check($sformatf("rl_pulse_c%0d", c), expired_pulse, (c % 2 == 0) ? 1 : 0);
      check($sformatf("rl_busy_c%0d", c), busy, 1);
    end
    do_stop();
    check("rl_stop_busy", busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
